// File: rtl/code_conv_display_if.sv
// ---------------------------------------------------------------------------
// code_conv_display_if
// Handshake bundle between a code-word source and the code_conv_display
// block.
//   in_valid  : source -> block, in_code/mode are valid
//   in_ready  : block -> source, block can take a word this cycle
//   in_code   : source -> block, N_BITS code word
//   mode      : source -> block, conversion mode
//   out_valid : block -> sink, one-cycle pulse when out_code is new
//   out_code  : block -> sink, last converted word
// ---------------------------------------------------------------------------
interface code_conv_display_if #(
    parameter int N_BITS = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] in_code;
    logic [1:0]        mode;
    logic              out_valid;
    logic [N_BITS-1:0] out_code;

    modport master (
        output in_valid, in_code, mode,
        input  in_ready, out_valid, out_code
    );

    modport slave (
        input  in_valid, in_code, mode,
        output in_ready, out_valid, out_code
    );
endinterface

// File: rtl/code_conv_display.sv
// ---------------------------------------------------------------------------
// code_conv_display
// Accepts an N_BITS code word over a valid/ready handshake, converts it one
// bit per clock (MSB first) in the selected mode, holds the result and
// drives a time-multiplexed N_BITS-digit 7-segment display that shows each
// result bit as a '0' or '1' glyph.
//   clk     : sole clock, rising edge
//   reset   : asynchronous, active-high
//   clear   : synchronous return to IDLE, display blanked, out_code kept
//   bus     : handshake bundle (slave side), see code_conv_display_if
//   seg     : segments a..g on seg[0]..seg[6]
//   dig_en  : one-hot digit enable (one-cold when ACTIVE_LOW)
// Modes: 00 pass, 01 Gray->binary, 10 binary->Gray, 11 pass.
// ---------------------------------------------------------------------------
module code_conv_display #(
    parameter int N_BITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    code_conv_display_if.slave   bus,
    output logic [6:0]           seg,
    output logic [N_BITS-1:0]    dig_en
);

    localparam int IDX_W = $clog2(N_BITS);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic             INV      = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2
    } state_t;

    function automatic logic [6:0] glyph(input logic b);
        return b ? 7'b0000110 : 7'b0111111;
    endfunction

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [N_BITS-1:0]   out_code_q, out_code_d;
    logic [N_BITS-1:0]   disp_q, disp_d;
    logic [IDX_W-1:0]    d_q, d_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [6:0]          seg_q, seg_d;
    logic [N_BITS-1:0]   dig_q, dig_d;

    // Datapath registers: no reset, always loaded before use.
    logic [N_BITS-1:0]   code_q, code_d;
    logic [1:0]          mode_q, mode_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_BITS-1:0]   work_q, work_d;
    // Result bit and code bit from the previous (higher) position; both start
    // at 0 so the MSB falls out of the same XOR as every other bit.
    logic                prev_r_q, prev_r_d;
    logic                prev_c_q, prev_c_d;

    logic                accept;
    logic                cur_c;
    logic                conv_bit;

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        out_code_d  = out_code_q;
        disp_d      = disp_q;
        d_d         = d_q;
        div_d       = div_q;
        seg_d       = seg_q;
        dig_d       = dig_q;
        code_d      = code_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        work_d      = work_q;
        prev_r_d    = prev_r_q;
        prev_c_d    = prev_c_q;

        accept = bus.in_valid && in_ready_q && !clear;
        cur_c  = code_q[idx_q];
        case (mode_q)
            2'b01:   conv_bit = prev_r_q ^ cur_c;
            2'b10:   conv_bit = prev_c_q ^ cur_c;
            default: conv_bit = cur_c;
        endcase

        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, SHOW: begin
                    if (accept) begin
                        state_d  = CONVERT;
                        code_d   = bus.in_code;
                        mode_d   = bus.mode;
                        idx_d    = IDX_LAST;
                        work_d   = '0;
                        prev_r_d = 1'b0;
                        prev_c_d = 1'b0;
                    end
                end
                CONVERT: begin
                    work_d[idx_q] = conv_bit;
                    prev_r_d      = conv_bit;
                    prev_c_d      = cur_c;
                    if (idx_q == '0) begin
                        state_d     = SHOW;
                        out_code_d  = work_d;
                        disp_d      = work_d;
                        out_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        in_ready_d = (state_d != CONVERT);

        // Scanner: parked and blank in IDLE; seg/dig_en only refresh on
        // leaving IDLE or on a digit advance, so a result load shows up at
        // the next digit step rather than mid-digit.
        if (state_d == IDLE) begin
            d_d   = '0;
            div_d = '0;
            seg_d = '0;
            dig_d = '0;
        end else if (state_q == IDLE) begin
            seg_d        = glyph(disp_d[d_q]);
            dig_d        = '0;
            dig_d[d_q]   = 1'b1;
        end else if (div_q == DIV_LAST) begin
            div_d        = '0;
            d_d          = (d_q == IDX_LAST) ? '0 : d_q + 1'b1;
            seg_d        = glyph(disp_d[d_d]);
            dig_d        = '0;
            dig_d[d_d]   = 1'b1;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            disp_q      <= '0;
            d_q         <= '0;
            div_q       <= '0;
            seg_q       <= '0;
            dig_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            disp_q      <= disp_d;
            d_q         <= d_d;
            div_q       <= div_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
        end
    end

    always_ff @(posedge clk) begin
        code_q   <= code_d;
        mode_q   <= mode_d;
        idx_q    <= idx_d;
        work_q   <= work_d;
        prev_r_q <= prev_r_d;
        prev_c_q <= prev_c_d;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;
    // Polarity flip against a constant keeps the outputs glitch-free.
    assign seg    = seg_q ^ {7{INV}};
    assign dig_en = dig_q ^ {N_BITS{INV}};

endmodule

// File: tb/tb_code_conv_display.sv
// Scoreboard bench for code_conv_display: stimulus pushes expected out_code
// values, a monitor pops and compares on every out_valid.
module tb_code_conv_display;
    localparam logic [6:0] G0 = 7'b0111111;
    localparam logic [6:0] G1 = 7'b0000110;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic [6:0] seg0, seg1;
    logic [3:0] dig0, dig1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    code_conv_display_if #(.N_BITS(4)) b0();
    code_conv_display_if #(.N_BITS(4)) b1();

    code_conv_display #(.N_BITS(4), .SCAN_DIV(2), .ACTIVE_LOW(0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(b0), .seg(seg0), .dig_en(dig0));
    code_conv_display #(.N_BITS(4), .SCAN_DIV(2), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .reset(reset), .clear(clear), .bus(b1), .seg(seg1), .dig_en(dig1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (b0.out_valid === 1'b1) begin
            if (q0.size() == 0) chk("unexpected out_valid dut", 1, 0);
            else chk("out_code dut", 32'(b0.out_code), 32'(q0.pop_front()));
        end
        if (b1.out_valid === 1'b1) begin
            if (q1.size() == 0) chk("unexpected out_valid dut_al", 1, 0);
            else chk("out_code dut_al", 32'(b1.out_code), 32'(q1.pop_front()));
        end
    end

    // Wait for in_ready, present one word for one accepting edge.
    task automatic send(input int sel, input logic [3:0] code, input logic [1:0] md);
        logic rdy;
        rdy = 1'b0;
        for (int k = 0; k < 30 && !rdy; k++) begin
            @(negedge clk);
            rdy = (sel == 0) ? b0.in_ready : b1.in_ready;
        end
        if (!rdy) chk("in_ready timeout", 0, 1);
        if (sel == 0) begin b0.in_valid = 1'b1; b0.in_code = code; b0.mode = md; end
        else          begin b1.in_valid = 1'b1; b1.in_code = code; b1.mode = md; end
        @(posedge clk);
        #1;
        b0.in_valid = 1'b0;
        b1.in_valid = 1'b0;
    endtask

    task automatic wait_ov(input int sel);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = (sel == 0) ? b0.out_valid : b1.out_valid;
        end
        if (!seen) chk("out_valid timeout", 0, 1);
    endtask

    // Wait until dig_en steps onto the given pattern.
    task automatic wait_digit(input int sel, input logic [3:0] pat);
        logic [3:0] prev, cur;
        logic hit;
        hit = 1'b0;
        prev = (sel == 0) ? dig0 : dig1;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            cur = (sel == 0) ? dig0 : dig1;
            hit = (cur == pat) && (prev != pat);
            prev = cur;
        end
        if (!hit) chk("scan timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowcnt;
        int acc_cnt;
        int acc_cyc[$];
        logic rdy;
        logic [3:0] dpat;
        logic [6:0] spat;

        b0.in_valid = 0; b0.in_code = 0; b0.mode = 0;
        b1.in_valid = 0; b1.in_code = 0; b1.mode = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 32'(b0.in_ready), 1);
        chk("rst out_valid", 32'(b0.out_valid), 0);
        chk("rst out_code", 32'(b0.out_code), 0);
        chk("rst seg", 32'(seg0), 0);
        chk("rst dig_en", 32'(dig0), 0);
        chk("rst seg al", 32'(seg1), 32'h7f);
        chk("rst dig_en al", 32'(dig1), 32'hf);
        @(negedge clk);
        reset = 1'b0;

        // Gray->binary with latency / in_ready window
        send(0, 4'b1011, 2'b01);
        q0.push_back(4'b1101);
        lowcnt = 0;
        rdy = 1'b0;
        for (int k = 0; k < 20 && !rdy; k++) begin
            @(negedge clk);
            rdy = b0.in_ready;
            if (!rdy) lowcnt++;
        end
        chk("g2b in_ready low cycles", 32'(lowcnt), 4);
        chk("g2b out_valid with ready", 32'(b0.out_valid), 1);
        @(negedge clk);
        chk("g2b out_valid one cycle", 32'(b0.out_valid), 0);

        // binary->Gray, in_valid held: accepted every 5 clocks
        @(posedge clk); #1;
        b0.in_valid = 1'b1; b0.in_code = 4'b1101; b0.mode = 2'b10;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            rdy = b0.in_ready;
            @(posedge clk);
            if (rdy) begin q0.push_back(4'b1011); acc_cyc.push_back(c); end
        end
        #1 b0.in_valid = 1'b0;
        acc_cnt = acc_cyc.size();
        chk("b2g accept count", 32'(acc_cnt), 3);
        if (acc_cnt == 3) begin
            chk("b2g gap1", 32'(acc_cyc[1] - acc_cyc[0]), 5);
            chk("b2g gap2", 32'(acc_cyc[2] - acc_cyc[1]), 5);
        end
        repeat (6) @(negedge clk);

        // Extra words during CONVERT ignored
        send(0, 4'b0110, 2'b00);
        q0.push_back(4'b0110);
        b0.in_valid = 1'b1; b0.in_code = 4'b1111; b0.mode = 2'b01;
        repeat (3) @(posedge clk);
        #1 b0.in_valid = 1'b0;
        wait_ov(0);
        chk("hold ignored out_code", 32'(b0.out_code), 32'b0110);
        repeat (8) @(negedge clk);

        // Scan pattern, mode 00, 0101
        send(0, 4'b0101, 2'b00);
        q0.push_back(4'b0101);
        wait_ov(0);
        wait_digit(0, 4'b0001);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            dpat = 4'b0001 << ((k / 2) % 4);
            spat = (((k / 2) % 2) == 0) ? G1 : G0;
            chk($sformatf("scan dig_en %0d", k), 32'(dig0), 32'(dpat));
            chk($sformatf("scan seg %0d", k), 32'(seg0), 32'(spat));
        end

        // clear on the 2nd CONVERT cycle
        send(0, 4'b1111, 2'b00);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("clear in_ready", 32'(b0.in_ready), 1);
        chk("clear seg blank", 32'(seg0), 0);
        chk("clear dig_en off", 32'(dig0), 0);
        chk("clear out_code kept", 32'(b0.out_code), 32'b0101);
        repeat (8) @(negedge clk);
        chk("clear stays idle seg", 32'(seg0), 0);

        // clear and in_valid together: not accepted
        b0.in_valid = 1'b1; b0.in_code = 4'b0011; b0.mode = 2'b00; clear = 1'b1;
        @(posedge clk); #1;
        b0.in_valid = 1'b0; clear = 1'b0;
        @(negedge clk);
        chk("clear+valid in_ready", 32'(b0.in_ready), 1);
        chk("clear+valid seg", 32'(seg0), 0);
        repeat (8) @(negedge clk);
        chk("clear+valid out_code", 32'(b0.out_code), 32'b0101);

        // ACTIVE_LOW instance
        send(1, 4'b0001, 2'b00);
        q1.push_back(4'b0001);
        wait_ov(1);
        wait_digit(1, 4'b1110);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            dpat = ~(4'b0001 << (k / 2));
            spat = ((k / 2) == 0) ? 7'b1111001 : 7'b1000000;
            chk($sformatf("al dig_en %0d", k), 32'(dig1), 32'(dpat));
            chk($sformatf("al seg %0d", k), 32'(seg1), 32'(spat));
        end

        // Asynchronous reset in SHOW, checked before the next edge
        send(0, 4'b0110, 2'b00);
        q0.push_back(4'b0110);
        wait_ov(0);
        #2 reset = 1'b1;
        #1;
        chk("async rst seg", 32'(seg0), 0);
        chk("async rst dig_en", 32'(dig0), 0);
        chk("async rst out_valid", 32'(b0.out_valid), 0);
        chk("async rst out_code", 32'(b0.out_code), 0);
        chk("async rst in_ready", 32'(b0.in_ready), 1);
        chk("async rst seg al", 32'(seg1), 32'h7f);
        chk("async rst dig_en al", 32'(dig1), 32'hf);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        chk("scoreboard drained dut", 32'(q0.size()), 0);
        chk("scoreboard drained dut_al", 32'(q1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
